// File: rtl/sift_pkg.sv
// Shared definitions for the descriptor path: streamer state encoding and descriptor geometry.
package sift_pkg;

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} streamer_state;

  localparam int DESC_WORD_WIDTH              = 24;
  localparam int DESCRIPTOR_WORDS_PER_KEYPOINT = 4;

endpackage

// File: rtl/descriptor_streamer_if.sv
// Byte stream from the descriptor streamer to the UART TX path; valid/ready, data held while stalled.
interface descriptor_streamer_if;

  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);

endinterface

// File: rtl/word_serializer.sv
// Loads one descriptor word and presents it MSB byte first; one byte per handshake, no bubbles.
// Holds byte_out/byte_valid while byte_ready is low; last_accepted marks the final byte's handshake.
module word_serializer #(
  parameter int WORD_WIDTH = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  byte_ready,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic                  last_accepted
);

  localparam int NB = WORD_WIDTH / 8;
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;

  logic [WORD_WIDTH-1:0] word_reg;
  logic [SW-1:0]         byte_sel;
  logic                  handshake;
  logic                  is_last;

  assign handshake     = byte_valid & byte_ready;
  assign is_last       = (byte_sel == SW'(NB - 1));
  assign last_accepted = handshake & is_last;
  assign byte_out      = 8'(word_reg >> (WORD_WIDTH - 8 * (int'(byte_sel) + 1)));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      word_reg   <= '0;
      byte_sel   <= '0;
      byte_valid <= 1'b0;
    end else if (load) begin
      word_reg   <= word_in;
      byte_sel   <= '0;
      byte_valid <= 1'b1;
    end else if (handshake) begin
      if (is_last) byte_valid <= 1'b0;
      else         byte_sel   <= byte_sel + 1'b1;
    end
  end

endmodule

// File: rtl/descriptor_streamer.sv
// Walks the descriptor BRAM from address 0 and streams each word MSB byte first until the end-of-list marker or top of memory.
// First byte BRAM_LATENCY+2 cycles after start; BRAM_LATENCY+1 idle cycles between words; stalls freely on byte_ready.
module descriptor_streamer
  import sift_pkg::*;
#(
  parameter int NUMBER_DESCRIPTORS = 4000,
  parameter int WORD_WIDTH         = DESC_WORD_WIDTH,
  parameter int BRAM_LATENCY       = 2
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  start,
  output logic [$clog2(NUMBER_DESCRIPTORS)-1:0] desc_read_addr,
  input  logic [WORD_WIDTH-1:0]                 desc_read,
  descriptor_streamer_if.master                 stream,
  output logic [$clog2(NUMBER_DESCRIPTORS)-2:0] keypoint_count,
  output logic                                  busy,
  output logic                                  streaming_done
);

  localparam int AW = $clog2(NUMBER_DESCRIPTORS);
  localparam int CW = $clog2(BRAM_LATENCY + 2);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_READ = READ;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]    state;
  logic [CW-1:0] rd_cnt;
  logic          word_zero;
  logic          prev_zero;
  logic          load;
  logic          last_accepted;
  logic          is_marker;
  logic          at_top;
  logic          kp_last;

  // Read data is stable one cycle after the pipeline fills, so sample on the last wait cycle.
  assign load      = (state == ST_READ) && (rd_cnt == CW'(BRAM_LATENCY));
  // Second marker word sits one past a keypoint boundary, right after another zero word.
  assign is_marker = word_zero && prev_zero && (desc_read_addr[1:0] == 2'd1);
  assign at_top    = (desc_read_addr == AW'(NUMBER_DESCRIPTORS - 1));
  assign kp_last   = (desc_read_addr[1:0] == 2'(DESCRIPTOR_WORDS_PER_KEYPOINT - 1));

  word_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .load          (load),
    .word_in       (desc_read),
    .byte_ready    (stream.byte_ready),
    .byte_out      (stream.byte_out),
    .byte_valid    (stream.byte_valid),
    .last_accepted (last_accepted)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= ST_IDLE;
      rd_cnt         <= '0;
      desc_read_addr <= '0;
      keypoint_count <= '0;
      busy           <= 1'b0;
      streaming_done <= 1'b0;
      word_zero      <= 1'b0;
      prev_zero      <= 1'b0;
    end else begin
      streaming_done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          desc_read_addr <= '0;
          keypoint_count <= '0;
          rd_cnt         <= '0;
          prev_zero      <= 1'b0;
          busy           <= 1'b1;
          state          <= ST_READ;
        end
        ST_READ: if (load) begin
          rd_cnt    <= '0;
          word_zero <= (desc_read == '0);
          state     <= ST_SEND;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
        ST_SEND: if (last_accepted) begin
          prev_zero <= word_zero;
          if (kp_last) keypoint_count <= keypoint_count + 1'b1;
          if (is_marker || at_top) begin
            streaming_done <= 1'b1;
            state          <= ST_DONE;
          end else begin
            desc_read_addr <= desc_read_addr + 1'b1;
            state          <= ST_READ;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
